// File: rtl/spi_pkg.sv
// Shared constants and FSM state encodings for the SPI loopback slice.
package spi_pkg;

    localparam int DATA_W  = 12;
    localparam int CLK_DIV = 10;
    localparam int CNT_W   = $clog2(CLK_DIV);
    localparam int BIT_W   = $clog2(DATA_W + 1);

    typedef logic [0:0] mst_state_t;
    localparam mst_state_t M_IDLE = 1'b0;
    localparam mst_state_t M_SEND = 1'b1;

    typedef logic [0:0] slv_state_t;
    localparam slv_state_t S_IDLE = 1'b0;
    localparam slv_state_t S_READ = 1'b1;

endpackage

// File: rtl/spi_if.sv
// User-side word bus of the loopback: request/data in, received word and done pulse out.
interface spi_if;
    import spi_pkg::*;

    logic              newd;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              done;

    modport master (output newd, din, input dout, done);
    modport slave  (input newd, din, output dout, done);
endinterface

// File: rtl/spi_master.sv
// SPI master: owns the sync_clock divider and serialises one word LSB first per cs frame.
module spi_master
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    output logic              sclk,
    output logic              cs,
    output logic              mosi
);

    logic [CNT_W-1:0]  cnt;
    logic              sync_clock;
    logic              rise;
    mst_state_t        state;
    logic [DATA_W-1:0] data;
    logic [BIT_W-1:0]  bitcnt;

    // rise is the clk edge on which sync_clock flips 0->1
    assign rise = (cnt == CNT_W'(CLK_DIV - 1)) && !sync_clock;
    assign sclk = sync_clock;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            sync_clock <= 1'b0;
        end else if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt        <= '0;
            sync_clock <= ~sync_clock;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= M_IDLE;
            cs     <= 1'b1;
            mosi   <= 1'b0;
            data   <= '0;
            bitcnt <= '0;
        end else if (rise) begin
            case (state)
                M_IDLE: begin
                    if (newd) begin
                        data   <= din;
                        cs     <= 1'b0;
                        mosi   <= din[0];
                        bitcnt <= BIT_W'(1);
                        state  <= M_SEND;
                    end
                end
                default: begin
                    // one extra rise after the last bit closes the frame
                    if (bitcnt == BIT_W'(DATA_W)) begin
                        cs     <= 1'b1;
                        mosi   <= 1'b0;
                        bitcnt <= '0;
                        state  <= M_IDLE;
                    end else begin
                        mosi   <= data[bitcnt];
                        bitcnt <= bitcnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI slave: samples mosi on sclk falling edges while cs is low and emits the word with a done pulse.
module spi_slave
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done
);

    logic              sclk_q;
    logic              fall;
    slv_state_t        state;
    logic [BIT_W-1:0]  bitcnt;
    logic [DATA_W-2:0] shreg;

    assign fall = sclk_q && !sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= 1'b0;
            state  <= S_IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            dout   <= '0;
            done   <= 1'b0;
        end else begin
            sclk_q <= sclk;
            done   <= 1'b0;
            if (cs) begin
                state  <= S_IDLE;
                bitcnt <= '0;
            end else if (fall) begin
                // LSB first: each new bit enters at the top and older bits slide down
                if (state == S_READ && bitcnt == BIT_W'(DATA_W - 1)) begin
                    dout   <= {mosi, shreg};
                    done   <= 1'b1;
                    bitcnt <= '0;
                    state  <= S_IDLE;
                end else begin
                    shreg  <= {mosi, shreg[DATA_W-2:1]};
                    bitcnt <= (state == S_IDLE) ? BIT_W'(1) : bitcnt + 1'b1;
                    state  <= S_READ;
                end
            end
        end
    end

endmodule

// File: rtl/spi_loopback_top.sv
// End-to-end SPI loopback: master S1 drives sclk/cs/mosi straight into slave S2.
module spi_loopback_top
    import spi_pkg::*;
(
    input logic  clk,
    input logic  rst,
    spi_if.slave bus
);

    logic sclk;
    logic cs;
    logic mosi;

    spi_master S1 (
        .clk  (clk),
        .rst  (rst),
        .newd (bus.newd),
        .din  (bus.din),
        .sclk (sclk),
        .cs   (cs),
        .mosi (mosi)
    );

    spi_slave S2 (
        .clk  (clk),
        .rst  (rst),
        .sclk (sclk),
        .cs   (cs),
        .mosi (mosi),
        .dout (bus.dout),
        .done (bus.done)
    );

endmodule

// File: tb/tb_spi_loopback_top.sv
// Directed bench for spi_loopback_top: reset, latency, boundaries, back-to-back, ignored newd, abort.
module tb_spi_loopback_top;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_if bus ();

    spi_loopback_top dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_cs(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dut.S1.cs === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_word(input logic [DATA_W-1:0] w, input string tag, input bit chk_mosi);
        int r0;
        int dc0;
        bit ok;
        dc0      = done_cnt;
        bus.din  = w;
        bus.newd = 1'b1;
        wait_cs(1'b0, 40, ok);
        check({tag, "_start"}, 32'(ok), 32'd1);
        if (!ok) begin
            bus.newd = 1'b0;
            return;
        end
        r0       = cyc;
        bus.newd = 1'b0;
        if (chk_mosi) begin
            for (int k = 0; k < DATA_W; k++) begin
                while (cyc < r0 + 20 * k + 5) @(negedge clk);
                check($sformatf("%s_mosi%0d", tag, k), 32'(dut.S1.mosi), 32'(w[k]));
            end
        end
        wait_done(300, ok);
        check({tag, "_latency"}, 32'(cyc - r0), 32'd231);
        check({tag, "_dout"}, 32'(bus.dout), 32'(w));
        @(negedge clk);
        check({tag, "_done_width"}, 32'(bus.done), 32'd0);
        wait_cs(1'b1, 40, ok);
        check({tag, "_cs_high"}, 32'(cyc - r0), 32'd240);
        check({tag, "_ndone"}, 32'(done_cnt - dc0), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int rel_cyc;
        int t1;
        int t2;
        int r0;
        int r_prev;
        int dc0;
        bit ok;
        bit prev;
        logic [DATA_W-1:0] words [7];

        bus.newd = 1'b0;
        bus.din  = '0;

        // reset state and sync_clock start-up
        repeat (5) @(negedge clk);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_cs", 32'(dut.S1.cs), 32'd1);
        check("rst_sync", 32'(dut.S1.sync_clock), 32'd0);
        rst     = 1'b0;
        rel_cyc = cyc;
        t1      = -1;
        t2      = -1;
        prev    = 1'b0;
        for (int i = 0; i < 100 && t2 < 0; i++) begin
            @(negedge clk);
            if (dut.S1.sync_clock && !prev) begin
                if (t1 < 0) t1 = cyc;
                else        t2 = cyc;
            end
            prev = dut.S1.sync_clock;
        end
        check("sync_first_rise", 32'(t1 - rel_cyc), 32'd10);
        check("sync_period", 32'(t2 - t1), 32'd20);

        // single word with bit-level mosi check
        run_word(12'h2A5, "single", 1'b1);

        // boundary words
        run_word(12'h000, "zero", 1'b0);
        run_word(12'hFFF, "ones", 1'b0);
        run_word(12'h001, "one", 1'b0);

        // back-to-back with newd held high
        foreach (words[i]) words[i] = DATA_W'($urandom_range(1000, 1));
        dc0      = done_cnt;
        r_prev   = 0;
        bus.din  = words[0];
        bus.newd = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) wait_cs(1'b1, 40, ok);
            wait_cs(1'b0, 40, ok);
            if (i > 0) check($sformatf("b2b_gap%0d", i), 32'(cyc - r_prev), 32'd260);
            r_prev = cyc;
            wait_done(300, ok);
            check($sformatf("b2b_dout%0d", i), 32'(bus.dout), 32'(words[i]));
            if (i < 6) bus.din = words[i + 1];
            else       bus.newd = 1'b0;
        end
        wait_cs(1'b1, 40, ok);
        check("b2b_ndone", 32'(done_cnt - dc0), 32'd7);

        // newd during SEND must be ignored
        dc0      = done_cnt;
        bus.din  = 12'h5C3;
        bus.newd = 1'b1;
        wait_cs(1'b0, 40, ok);
        r0       = cyc;
        bus.newd = 1'b0;
        while (cyc < r0 + 50) @(negedge clk);
        bus.din  = 12'hABC;
        bus.newd = 1'b1;
        while (cyc < r0 + 90) @(negedge clk);
        bus.newd = 1'b0;
        wait_done(300, ok);
        check("ignore_dout", 32'(bus.dout), 32'h5C3);
        wait_cs(1'b1, 40, ok);
        repeat (60) @(negedge clk);
        check("ignore_no_restart", 32'(dut.S1.cs), 32'd1);
        check("ignore_ndone", 32'(done_cnt - dc0), 32'd1);

        // abort at bit 6
        dc0      = done_cnt;
        bus.din  = 12'h3C7;
        bus.newd = 1'b1;
        wait_cs(1'b0, 40, ok);
        r0       = cyc;
        bus.newd = 1'b0;
        while (cyc < r0 + 6 * 20 + 5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_cs", 32'(dut.S1.cs), 32'd1);
        check("abort_dout", 32'(bus.dout), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("abort_ndone", 32'(done_cnt - dc0), 32'd0);
        check("abort_cs_idle", 32'(dut.S1.cs), 32'd1);
        check("abort_dout_hold", 32'(bus.dout), 32'd0);
        run_word(12'h6B4, "after_abort", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
